// File: rtl/gpu_seq_pkg.sv
// gpu_seq_pkg: shared definitions for the rectangle-fill sequencer.
//   - seq_state_t : sequencer FSM states (3-bit encoding)
//   - CMD_W       : width of a packed command {x, y, w, h, color}
//   - CMD_*_LSB   : bit offsets of each field inside a packed command
//   - DEFAULT_H_RES / DEFAULT_V_RES : default visible screen size
package gpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4
  } seq_state_t;

  // Packed command layout, MSB first: x[87:72] y[71:56] w[55:40] h[39:24] color[23:0]
  localparam int CMD_W         = 88;
  localparam int CMD_X_LSB     = 72;
  localparam int CMD_Y_LSB     = 56;
  localparam int CMD_W_LSB     = 40;
  localparam int CMD_H_LSB     = 24;
  localparam int CMD_COLOR_LSB = 0;

  localparam int DEFAULT_H_RES = 1024;
  localparam int DEFAULT_V_RES = 600;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: synchronous command FIFO for the rectangle sequencer.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset (flushes the FIFO)
//   push       : write push_data this cycle (ignored when full)
//   push_data  : command to enqueue
//   pop        : drop the head entry this cycle (ignored when empty)
//   head       : current head entry, read straight from the storage registers
//   full/empty : derived from the registered fill level
//   level      : number of stored entries
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 88
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and level bookkeeping. DEPTH is a power of two, so the
  // pointers simply wrap at their natural width.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gpu_rect_sequencer.sv
// gpu_rect_sequencer: queues CPU rectangle-fill commands and replays each one
// as a series of single-row requests to the SDRAM row-fill engine, honouring
// the engine's enable/busy handshake.
// Build option: define GPU_RECT_CLIP_EN to clip rectangles to H_RES x V_RES
// (fully off-screen commands are dropped). Without it commands pass verbatim.
// Ports:
//   clk, rstn            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake; accepted when both are high
//   cmd_x/y/w/h/color    : rectangle origin, size and RGB888 colour
//   fill_x/y/pixel/len   : row request fields towards the fill engine
//   fill_enable          : row request strobe, held until busy is seen
//   fill_busy            : fill engine busy
//   fifo_level           : number of queued commands
//   idle                 : nothing queued and the FSM is in IDLE
module gpu_rect_sequencer
  import gpu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int H_RES      = DEFAULT_H_RES,
  parameter int V_RES      = DEFAULT_V_RES
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [15:0]                   cmd_x,
  input  logic [15:0]                   cmd_y,
  input  logic [15:0]                   cmd_w,
  input  logic [15:0]                   cmd_h,
  input  logic [23:0]                   cmd_color,
  output logic [15:0]                   fill_x,
  output logic [15:0]                   fill_y,
  output logic [23:0]                   fill_pixel,
  output logic [23:0]                   fill_len,
  output logic                          fill_enable,
  input  logic                          fill_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          idle
);

  // Elaboration-time parameter sanity checks.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("gpu_rect_sequencer: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((H_RES < 1) || (H_RES > 65535) || (V_RES < 1) || (V_RES > 65535)) begin : g_bad_res
    $error("gpu_rect_sequencer: H_RES/V_RES must be within 1..65535");
  end

  logic [CMD_W-1:0] push_data;
  logic [CMD_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  seq_state_t       state;
  seq_state_t       state_nxt;

  logic [15:0]      cur_x;
  logic [15:0]      cur_y;
  logic [15:0]      cur_len;
  logic [15:0]      rows_left;
  logic [23:0]      cur_color;

  logic [15:0]      head_x;
  logic [15:0]      head_y;
  logic [15:0]      head_w;
  logic [15:0]      head_h;
  logic [23:0]      head_color;
  logic [15:0]      load_len;
  logic [15:0]      load_rows;
  logic             load_ok;

  assign push_data = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
  assign cmd_ready = ~fifo_full;

  gpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (cmd_valid & cmd_ready),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign head_x     = head[CMD_X_LSB +: 16];
  assign head_y     = head[CMD_Y_LSB +: 16];
  assign head_w     = head[CMD_W_LSB +: 16];
  assign head_h     = head[CMD_H_LSB +: 16];
  assign head_color = head[CMD_COLOR_LSB +: 24];

`ifdef GPU_RECT_CLIP_EN
  localparam logic [16:0] H_LIM = 17'(H_RES);
  localparam logic [16:0] V_LIM = 17'(V_RES);
  logic [16:0] room_x;
  logic [16:0] room_y;

  // Clipped geometry of the head command. The 17-bit room values cannot
  // overflow, and once the origin is on screen they are at most 65535.
  always_comb begin
    room_x    = H_LIM - {1'b0, head_x};
    room_y    = V_LIM - {1'b0, head_y};
    load_len  = head_w;
    load_rows = head_h;
    load_ok   = (head_w != 16'd0) && (head_h != 16'd0);
    if (({1'b0, head_x} >= H_LIM) || ({1'b0, head_y} >= V_LIM)) begin
      load_ok = 1'b0;
    end else begin
      if ({1'b0, head_w} > room_x) load_len  = room_x[15:0];
      if ({1'b0, head_h} > room_y) load_rows = room_y[15:0];
    end
  end
`else
  // Unclipped geometry: the head command is used as written; only empty
  // rectangles are thrown away.
  always_comb begin
    load_len  = head_w;
    load_rows = head_h;
    load_ok   = (head_w != 16'd0) && (head_h != 16'd0);
  end
`endif

  // FSM state register; reset abandons any rectangle in progress.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake logic. Busy is only looked at in ISSUE and
  // WAIT, so a busy left over from before the request cannot advance the FSM
  // out of IDLE or LOAD.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    fill_enable = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = LOAD;
      end
      LOAD: begin
        pop       = 1'b1;
        state_nxt = load_ok ? ISSUE : IDLE;
      end
      ISSUE: begin
        fill_enable = 1'b1;
        if (fill_busy) state_nxt = WAIT;
      end
      WAIT: begin
        if (!fill_busy) state_nxt = NEXT;
      end
      NEXT: begin
        if (rows_left == 16'd1) state_nxt = fifo_empty ? IDLE : LOAD;
        else                    state_nxt = ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: loaded from the FIFO head in LOAD, stepped one row in
  // NEXT and held otherwise, so the fill outputs stay stable through ISSUE
  // and WAIT. Discarded commands leave them untouched.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur_x     <= '0;
      cur_y     <= '0;
      cur_len   <= '0;
      rows_left <= '0;
      cur_color <= '0;
    end else if ((state == LOAD) && load_ok) begin
      cur_x     <= head_x;
      cur_y     <= head_y;
      cur_len   <= load_len;
      rows_left <= load_rows;
      cur_color <= head_color;
    end else if (state == NEXT) begin
      rows_left <= rows_left - 16'd1;
      cur_y     <= cur_y + 16'd1;
    end
  end

  assign fill_x     = cur_x;
  assign fill_y     = cur_y;
  assign fill_len   = {8'd0, cur_len};
  assign fill_pixel = cur_color;
  assign idle       = fifo_empty && (state == IDLE);

endmodule

// File: tb/tb_gpu_rect_sequencer.sv
// tb_gpu_rect_sequencer: directed self-checking bench for gpu_rect_sequencer.
// Expected row fills are queued when a command is driven and popped by a
// monitor whenever fill_enable rises. A small engine model answers requests
// with busy one cycle after enable, held for five cycles; it can be switched
// off so the bench drives busy by hand (stall and stale-busy cases).
module tb_gpu_rect_sequencer;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [23:0] len;
    logic [23:0] pixel;
  } fill_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_x;
  logic [15:0] cmd_y;
  logic [15:0] cmd_w;
  logic [15:0] cmd_h;
  logic [23:0] cmd_color;
  logic [15:0] fill_x;
  logic [15:0] fill_y;
  logic [23:0] fill_pixel;
  logic [23:0] fill_len;
  logic        fill_enable;
  logic        fill_busy;
  logic [2:0]  fifo_level;
  logic        idle;

  fill_t       sb[$];
  int          checks = 0;
  int          failures = 0;
  int          rise_count = 0;

  logic        engine_auto = 1'b0;
  logic        manual_busy = 1'b0;
  logic        eng_busy = 1'b0;
  logic        eng_armed = 1'b0;
  int          eng_cnt = 0;

  fill_t       exp_f;
  logic        prev_en = 1'b0;
  logic [95:0] cap;

  assign fill_busy = engine_auto ? eng_busy : manual_busy;

  gpu_rect_sequencer #(
    .FIFO_DEPTH (4),
    .H_RES      (1024),
    .V_RES      (600)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_w       (cmd_w),
    .cmd_h       (cmd_h),
    .cmd_color   (cmd_color),
    .fill_x      (fill_x),
    .fill_y      (fill_y),
    .fill_pixel  (fill_pixel),
    .fill_len    (fill_len),
    .fill_enable (fill_enable),
    .fill_busy   (fill_busy),
    .fifo_level  (fifo_level),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue one expected row fill per row of a rectangle.
  task automatic expect_rect(input logic [15:0] x, input logic [15:0] y, input logic [15:0] len,
                             input int rows, input logic [23:0] color);
    fill_t f;
    for (int r = 0; r < rows; r++) begin
      f.x     = x;
      f.y     = y + 16'(r);
      f.len   = {8'd0, len};
      f.pixel = color;
      sb.push_back(f);
    end
  endtask

  // Offer one command from a negedge and hold it until it is accepted.
  task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w,
                                input logic [15:0] h, input logic [23:0] color);
    int guard = 0;
    cmd_x     = x;
    cmd_y     = y;
    cmd_w     = w;
    cmd_h     = h;
    cmd_color = color;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_output("push_ready", 96'(cmd_ready), 96'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait, with a cycle budget, until every expected fill has been seen and
  // the sequencer and engine are quiet.
  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!(idle && (sb.size() == 0) && !fill_busy && !fill_enable) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output($sformatf("%s_done", tag), 96'(idle && (sb.size() == 0)), 96'd1);
  endtask

  // Fill engine model: arm on a visible enable, raise busy on the next
  // cycle, keep it up for five cycles, then drop it.
  initial begin
    forever begin
      @(negedge clk);
      if (!engine_auto) begin
        eng_busy  = 1'b0;
        eng_cnt   = 0;
        eng_armed = 1'b0;
      end else if (eng_cnt > 0) begin
        eng_cnt = eng_cnt - 1;
        if (eng_cnt == 0) eng_busy = 1'b0;
      end else if (eng_armed) begin
        eng_busy  = 1'b1;
        eng_cnt   = 5;
        eng_armed = 1'b0;
      end else if (fill_enable) begin
        eng_armed = 1'b1;
      end
    end
  end

  // Monitor: each rising fill_enable is one row request and is compared to
  // the scoreboard head; while enable stays up the request must not change.
  initial begin
    forever begin
      @(negedge clk);
      if (fill_enable && !prev_en) begin
        rise_count++;
        cap = 96'({fill_x, fill_y, fill_len, fill_pixel});
        if (sb.size() == 0) begin
          check_output("unexpected_fill", 96'(fill_y), 96'hFFFF_FFFF);
        end else begin
          exp_f = sb.pop_front();
          check_output("fill_row", cap, 96'({exp_f.x, exp_f.y, exp_f.len, exp_f.pixel}));
        end
      end else if (fill_enable && prev_en) begin
        check_output("enable_hold_stable", 96'({fill_x, fill_y, fill_len, fill_pixel}), cap);
      end
      prev_en = fill_enable;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int base;
    int n;

    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    check_output("rst_enable", 96'(fill_enable), 96'd0);
    check_output("rst_fill_fields", 96'({fill_x, fill_y, fill_len, fill_pixel}), 96'd0);
    check_output("rst_level", 96'(fifo_level), 96'd0);
    check_output("rst_ready", 96'(cmd_ready), 96'd1);
    check_output("rst_idle", 96'(idle), 96'd1);
    rstn        = 1'b1;
    engine_auto = 1'b1;
    @(negedge clk);

    $display("[TB] single 3-row rectangle");
    base = rise_count;
    expect_rect(16'd10, 16'd20, 16'd100, 3, 24'hFF0000);
    apply_stimulus(16'd10, 16'd20, 16'd100, 16'd3, 24'hFF0000);
    check_output("single_level", 96'(fifo_level), 96'd1);
    @(negedge clk);
    check_output("first_en_early", 96'(fill_enable), 96'd0);
    @(negedge clk);
    check_output("first_en_latency", 96'(fill_enable), 96'd1);
    wait_done("single", 300);
    check_output("single_rows", 96'(rise_count - base), 96'd3);
    check_output("single_idle", 96'(idle), 96'd1);

    $display("[TB] reset in the middle of a rectangle");
    base = rise_count;
    expect_rect(16'd40, 16'd50, 16'd64, 2, 24'h00AA55);
    apply_stimulus(16'd40, 16'd50, 16'd64, 16'd5, 24'h00AA55);
    apply_stimulus(16'd90, 16'd90, 16'd8, 16'd2, 24'h111111);
    n = 0;
    while (!((rise_count - base == 2) && fill_busy && !fill_enable) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("midrst_reached_row2_wait", 96'((rise_count - base == 2) && !fill_enable), 96'd1);
    rstn = 1'b0;
    @(negedge clk);
    check_output("midrst_enable", 96'(fill_enable), 96'd0);
    check_output("midrst_idle", 96'(idle), 96'd1);
    check_output("midrst_level", 96'(fifo_level), 96'd0);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check_output("midrst_no_more_fills", 96'(rise_count - base), 96'd2);
    check_output("midrst_sb_empty", 96'(sb.size()), 96'd0);

    $display("[TB] FIFO fill with a stalled engine");
    engine_auto = 1'b0;
    manual_busy = 1'b0;
    @(negedge clk);
    base = rise_count;
    expect_rect(16'd100, 16'd0, 16'd16, 1, 24'h000001);
    apply_stimulus(16'd100, 16'd0, 16'd16, 16'd1, 24'h000001);
    for (int i = 1; i <= 4; i++) begin
      expect_rect(16'(100 + i), 16'(i), 16'd16, 1, 24'(i + 1));
      apply_stimulus(16'(100 + i), 16'(i), 16'd16, 16'd1, 24'(i + 1));
    end
    check_output("stall_level_full", 96'(fifo_level), 96'd4);
    check_output("stall_ready_low", 96'(cmd_ready), 96'd0);
    expect_rect(16'd105, 16'd5, 16'd16, 1, 24'h000006);
    cmd_x     = 16'd105;
    cmd_y     = 16'd5;
    cmd_w     = 16'd16;
    cmd_h     = 16'd1;
    cmd_color = 24'h000006;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("stall_fifth_held", 96'({cmd_ready, fifo_level}), 96'({1'b0, 3'd4}));
    end
    check_output("stall_single_request", 96'(rise_count - base), 96'd1);
    engine_auto = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("stall_fifth_ready", 96'(cmd_ready), 96'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("stall", 800);
    check_output("stall_rows", 96'(rise_count - base), 96'd6);

    $display("[TB] zero-width and zero-height commands");
    base = rise_count;
    apply_stimulus(16'd1, 16'd1, 16'd0, 16'd5, 24'h0000FF);
    apply_stimulus(16'd2, 16'd2, 16'd5, 16'd0, 24'h00FF00);
    expect_rect(16'd300, 16'd40, 16'd7, 1, 24'hABCDEF);
    apply_stimulus(16'd300, 16'd40, 16'd7, 16'd1, 24'hABCDEF);
    n = 0;
    while (!fill_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("zero_skip_latency", 96'(n), 96'd4);
    wait_done("zero", 200);
    check_output("zero_rows", 96'(rise_count - base), 96'd1);

    $display("[TB] off-screen rectangle");
    base = rise_count;
`ifdef GPU_RECT_CLIP_EN
    expect_rect(16'd1000, 16'd598, 16'd24, 2, 24'h00FF00);
`else
    expect_rect(16'd1000, 16'd598, 16'd100, 10, 24'h00FF00);
`endif
    apply_stimulus(16'd1000, 16'd598, 16'd100, 16'd10, 24'h00FF00);
`ifdef GPU_RECT_CLIP_EN
    apply_stimulus(16'd1024, 16'd10, 16'd5, 16'd5, 24'h0F0F0F);
`endif
    wait_done("edge", 600);
`ifdef GPU_RECT_CLIP_EN
    check_output("edge_rows", 96'(rise_count - base), 96'd2);
`else
    check_output("edge_rows", 96'(rise_count - base), 96'd10);
`endif

    $display("[TB] stale busy before enable");
    engine_auto = 1'b0;
    manual_busy = 1'b1;
    @(negedge clk);
    base = rise_count;
    expect_rect(16'd5, 16'd7, 16'd8, 1, 24'h123456);
    apply_stimulus(16'd5, 16'd7, 16'd8, 16'd1, 24'h123456);
    repeat (2) @(negedge clk);
    check_output("stale_enable_up", 96'(fill_enable), 96'd1);
    @(negedge clk);
    check_output("stale_enable_down", 96'(fill_enable), 96'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("stale_hold_outputs", 96'({fill_x, fill_y, fill_len, fill_pixel}),
                   96'({16'd5, 16'd7, 24'd8, 24'h123456}));
      check_output("stale_not_idle", 96'(idle), 96'd0);
    end
    manual_busy = 1'b0;
    wait_done("stale", 100);
    check_output("stale_rows", 96'(rise_count - base), 96'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
